conv2d_chan_sched: RTL and testbench

- Control FSM that time-multiplexes one conv2d_channel engine across IN_CHANNEL input channels for one convolution job.
- Accepts a job via valid/ready and selects each input channel in turn.
- For each channel it pulses the engine start, waits for done, then strobes the partial-sum accumulator.
- After the last channel it runs the bias/activation post stage and presents the result under an out_valid/out_ready handshake.

---
 rtl/conv2d_pkg.sv | 29 ++
 rtl/conv2d_wdt.sv | 43 ++++
 rtl/conv2d_chan_sched.sv | 152 +++++++++++++++
 tb/tb_conv2d_chan_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_pkg.sv
// Shared state encoding, sizing helpers and defaults for the conv2d schedulers.
package conv2d_pkg;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_POST_LATENCY   = 2;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b000_0001,
        S_START = 7'b000_0010,
        S_WAIT  = 7'b000_0100,
        S_ACC   = 7'b000_1000,
        S_POST  = 7'b001_0000,
        S_OUT   = 7'b010_0000,
        S_ERR   = 7'b100_0000
    } sched_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned ch_width(input int unsigned n_chan);
        return $clog2((n_chan > 1) ? n_chan : 2);
    endfunction

    function automatic int unsigned wdt_width(input int unsigned timeout);
        return clog2_min1(timeout);
    endfunction

endpackage

// File: rtl/conv2d_wdt.sv
// Loadable watchdog counter: clear, load, count-enable; saturates at LIMIT-1
// and flags expiry there instead of wrapping.
module conv2d_wdt
    import conv2d_pkg::*;
#(
    parameter int unsigned LIMIT = DEF_TIMEOUT_CYCLES,
    parameter int unsigned WIDTH = wdt_width(LIMIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q < LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/conv2d_chan_sched.sv
// Sequences one conv2d_channel engine across every input channel of a job,
// then runs bias/activation and presents the result via out_valid/out_ready.
module conv2d_chan_sched
    import conv2d_pkg::*;
#(
    parameter int unsigned IN_CHANNEL     = 3,
    parameter int unsigned POST_LATENCY   = DEF_POST_LATENCY,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned CH_W           = ch_width(IN_CHANNEL)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    output logic            ready,
    input  logic            abort,
    output logic [CH_W-1:0] chan_sel,
    output logic            eng_start,
    input  logic            eng_done,
    output logic            acc_clear,
    output logic            acc_en,
    output logic            post_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            err_timeout
);

    localparam int unsigned     PC_W      = clog2_min1(POST_LATENCY);
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(IN_CHANNEL - 1);
    localparam logic [PC_W-1:0] LAST_POST = PC_W'(POST_LATENCY - 1);

    sched_state_e    state_q, state_d;
    logic [CH_W-1:0] chan_idx_q, chan_idx_d;
    logic [PC_W-1:0] post_cnt_q, post_cnt_d;
    logic            acc_clear_d;
    logic            wdt_clr, wdt_en, wdt_expire;

    logic eng_start_q, acc_clear_q, acc_en_q, post_en_q, out_valid_q, busy_q, err_q;

    conv2d_wdt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (wdt_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (wdt_en),
        .expire_o   (wdt_expire)
    );

    always_comb begin
        state_d     = state_q;
        chan_idx_d  = chan_idx_q;
        post_cnt_d  = post_cnt_q;
        acc_clear_d = 1'b0;
        wdt_clr     = 1'b0;
        wdt_en      = 1'b0;
        if (abort) begin
            state_d    = S_IDLE;
            chan_idx_d = '0;
            post_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        state_d     = S_START;
                        chan_idx_d  = '0;
                        acc_clear_d = 1'b1;
                    end
                end
                S_START: begin
                    state_d = S_WAIT;
                    wdt_clr = 1'b1;
                end
                S_WAIT: begin
                    // done takes precedence over an expiry landing in the same cycle
                    if (eng_done) begin
                        state_d = S_ACC;
                    end else if (wdt_expire) begin
                        state_d = S_ERR;
                    end else begin
                        wdt_en = 1'b1;
                    end
                end
                S_ACC: begin
                    if (chan_idx_q == LAST_CH) begin
                        state_d    = S_POST;
                        post_cnt_d = '0;
                    end else begin
                        state_d    = S_START;
                        chan_idx_d = chan_idx_q + 1'b1;
                    end
                end
                S_POST: begin
                    if (post_cnt_q == LAST_POST) begin
                        state_d = S_OUT;
                    end else begin
                        post_cnt_d = post_cnt_q + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_d    = S_IDLE;
                        chan_idx_d = '0;
                    end
                end
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with it
    // and never see eng_done/out_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            chan_idx_q  <= '0;
            post_cnt_q  <= '0;
            eng_start_q <= 1'b0;
            acc_clear_q <= 1'b0;
            acc_en_q    <= 1'b0;
            post_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            chan_idx_q  <= chan_idx_d;
            post_cnt_q  <= post_cnt_d;
            eng_start_q <= (state_d == S_START);
            acc_clear_q <= acc_clear_d;
            acc_en_q    <= (state_d == S_ACC);
            post_en_q   <= (state_d == S_POST);
            out_valid_q <= (state_d == S_OUT);
            busy_q      <= (state_d != S_IDLE);
            err_q       <= (state_d == S_ERR);
        end
    end

    assign ready       = (state_q == S_IDLE);
    assign chan_sel    = chan_idx_q;
    assign eng_start   = eng_start_q;
    assign acc_clear   = acc_clear_q;
    assign acc_en      = acc_en_q;
    assign post_en     = post_en_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_conv2d_chan_sched.sv
// Scoreboard bench for conv2d_chan_sched: expected strobe timelines are derived
// from per-channel engine delays and queued; a monitor checks every strobe cycle.
module tb_conv2d_chan_sched;

    localparam int NCH = 3;
    localparam int PL  = 2;
    localparam int TO  = 16;

    logic clk = 1'b0;
    logic rst;
    logic valid, ready, abort, eng_start, acc_clear, acc_en, post_en;
    logic out_valid, out_ready, busy, err_timeout;
    logic eng_done = 1'b0;
    logic [1:0] chan_sel;

    logic valid1, ready1, eng_start1, eng_done1, acc_clear1, acc_en1;
    logic post_en1, out_valid1, out_ready1, busy1, err1;
    logic chan_sel1;

    conv2d_chan_sched #(
        .IN_CHANNEL(NCH), .POST_LATENCY(PL), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .ready(ready), .abort(abort),
        .chan_sel(chan_sel), .eng_start(eng_start), .eng_done(eng_done),
        .acc_clear(acc_clear), .acc_en(acc_en), .post_en(post_en),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .err_timeout(err_timeout)
    );

    conv2d_chan_sched #(
        .IN_CHANNEL(1), .POST_LATENCY(PL), .TIMEOUT_CYCLES(TO)
    ) u_dut1 (
        .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .abort(1'b0),
        .chan_sel(chan_sel1), .eng_start(eng_start1), .eng_done(eng_done1),
        .acc_clear(acc_clear1), .acc_en(acc_en1), .post_en(post_en1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1),
        .err_timeout(err1)
    );

    // ev bits: {eng_start, acc_clear, acc_en, post_en, out_valid, err_timeout rise}
    typedef struct {
        int         cyc;
        logic [5:0] ev;
        int         ch;
    } exp_t;

    exp_t sb[$];
    int   dq[$];
    int   cyc      = 0;
    int   spur_at  = -10;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   jd[NCH];
    int   last_c0  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: done arrives D cycles after each start (D=0: never).
    int eng_done_at = -1;
    always @(negedge clk) begin
        if (rst) begin
            dq.delete();
            eng_done_at = -1;
            eng_done    = 1'b0;
        end else begin
            eng_done = (cyc == eng_done_at) || (cyc == spur_at);
            if (eng_start) begin
                int d;
                d = (dq.size() > 0) ? dq.pop_front() : 0;
                eng_done_at = (d > 0) ? cyc + d : -1;
            end
        end
    end

    exp_t       mon_e;
    logic [5:0] mon_ev;
    logic       prev_err = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            prev_err = 1'b0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event cyc=%0d: got nothing, expected ev=%b ch=%0d",
                         mon_e.cyc, mon_e.ev, mon_e.ch);
            end
            mon_ev = {eng_start, acc_clear, acc_en, post_en, out_valid, err_timeout && !prev_err};
            if (mon_ev != '0) begin
                n_cmp++;
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d: got ev=%b ch=%0d, expected none",
                             cyc, mon_ev, chan_sel);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.ev != mon_ev || mon_e.ch != int'(chan_sel)) begin
                        n_bad++;
                        $display("FAIL event cyc=%0d: got ev=%b ch=%0d, expected ev=%b ch=%0d",
                                 cyc, mon_ev, chan_sel, mon_e.ev, mon_e.ch);
                    end
                end
            end
            prev_err = err_timeout;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Issue a job using delays jd[]; w = out_ready stall cycles.
    task automatic run_job(input int w, input bit tail);
        int t, tl, tout;
        bit hang;
        last_c0 = cyc;
        t    = cyc + 1;
        tl   = 0;
        hang = 1'b0;
        valid = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            dq.push_back(jd[k]);
            sb.push_back('{t, (k == 0) ? 6'b110000 : 6'b100000, k});
            if (jd[k] == 0) begin
                sb.push_back('{t + TO + 1, 6'b000001, k});
                hang = 1'b1;
                break;
            end
            tl = t + jd[k] + 1;
            sb.push_back('{tl, 6'b001000, k});
            t = tl + 1;
        end
        tout = tl + PL + 1;
        if (!hang) begin
            for (int p = 1; p <= PL; p++) sb.push_back('{tl + p, 6'b000100, NCH - 1});
            for (int o = 0; o <= w; o++) sb.push_back('{tout + o, 6'b000010, NCH - 1});
            spur_at = tl + 1;
        end
        at_cyc(last_c0 + 1);
        valid = 1'b0;
        at_cyc(last_c0 + 3);
        valid = 1'b1;
        at_cyc(last_c0 + 4);
        valid = 1'b0;
        if (hang || !tail) return;
        at_cyc(tout + w);
        out_ready = 1'b1;
        at_cyc(tout + w + 1);
        out_ready = 1'b0;
        chk("idle_ready", int'(ready), 1);
        chk("idle_busy", int'(busy), 0);
        chk("idle_chan_sel", int'(chan_sel), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c, g;
        logic [5:0] ex;
        rst = 1'b1; valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        valid1 = 1'b0; eng_done1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(ready), 1);
        chk("rst_outs", int'({busy, eng_start, acc_clear, acc_en, post_en, out_valid, err_timeout}), 0);
        chk("rst_chan_sel", int'(chan_sel), 0);
        rst = 1'b0;
        at_cyc(cyc + 1);

        jd = '{5, 5, 5}; run_job(0, 1);
        jd = '{5, 5, 5}; run_job(10, 1);
        jd = '{16, 2, 3}; run_job(1, 1);

        // Engine hang on channel 0, then abort out of ERR
        jd = '{0, 1, 1}; run_job(0, 0);
        at_cyc(last_c0 + 29);
        chk("err_sticky", int'(err_timeout), 1);
        chk("err_ready", int'(ready), 0);
        at_cyc(last_c0 + 30);
        abort = 1'b1;
        at_cyc(last_c0 + 31);
        abort = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_err", int'(err_timeout), 0);
        chk("abort_busy", int'(busy), 0);

        // Reset while waiting on channel 1
        jd = '{3, 9, 2}; run_job(0, 0);
        at_cyc(last_c0 + 9);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_outs", int'({busy, eng_start, acc_clear, acc_en, post_en, out_valid, err_timeout}), 0);
        chk("midrst_chan_sel", int'(chan_sel), 0);
        at_cyc(cyc + 2);
        rst = 1'b0;
        spur_at = -10;
        at_cyc(cyc + 1);

        for (int j = 0; j < 25; j++) begin
            g = $urandom_range(0, 3);
            if (g >= 2) spur_at = cyc + 1;
            at_cyc(cyc + g);
            for (int k = 0; k < NCH; k++)
                jd[k] = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(1, 8);
            run_job($urandom_range(0, 4), 1);
        end

        // Single-channel build, engine delay 3
        c = cyc;
        valid1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            at_cyc(c + i);
            valid1 = 1'b0;
            eng_done1 = (i == 4);
            ex = {i == 1, i == 1, i == 5, (i == 6) || (i == 7), i == 8, 1'b0};
            chk($sformatf("in1_cyc%0d", i),
                int'({eng_start1, acc_clear1, acc_en1, post_en1, out_valid1, chan_sel1}), int'(ex));
        end
        chk("in1_ready", int'(ready1), 1);

        at_cyc(cyc + 5);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
